ppu_scroll: RTL and testbench

- Owns the loopy scroll/address state of the PPU: current VRAM address v, temporary address t, fine X, and write toggle w.
- Sits directly upstream of the background renderer. It takes the renderer's increment/copy strobes (inc_cx, inc_y, return00) and its fetch selects (fetch_attr, fetch_chr, pattern_idx).
- Produces the 14-bit VRAM address, the fine_x scroll value, and the 2-bit attribute (attr_i) consumed by the renderer.
- Also applies CPU register writes to $2000, $2005 and $2006, CPU reads of $2002, and the PPUDATA post-increment.

---
 rtl/ppu_scroll_if.sv | 30 +++
 rtl/ppu_scroll.sv | 156 +++++++++++++++
 tb/tb_ppu_scroll.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ppu_scroll_if.sv
// Renderer/CPU-side bundle for the loopy scroll block: strobes, register access, VRAM address and attribute.
interface ppu_scroll_if;
  logic        rend;
  logic        inc_cx;
  logic        inc_y;
  logic        return00;
  logic        fetch_attr;
  logic        fetch_chr;
  logic [12:0] pattern_idx;
  logic        reg_wr;
  logic        reg_rd;
  logic [2:0]  reg_sel;
  logic [7:0]  reg_din;
  logic [7:0]  vram_din;
  logic [13:0] vram_addr;
  logic [2:0]  fine_x;
  logic [1:0]  attr_o;

  modport master (
    output rend, inc_cx, inc_y, return00, fetch_attr, fetch_chr, pattern_idx,
           reg_wr, reg_rd, reg_sel, reg_din, vram_din,
    input  vram_addr, fine_x, attr_o
  );

  modport slave (
    input  rend, inc_cx, inc_y, return00, fetch_attr, fetch_chr, pattern_idx,
           reg_wr, reg_rd, reg_sel, reg_din, vram_din,
    output vram_addr, fine_x, attr_o
  );
endinterface

// File: rtl/ppu_scroll.sv
// PPU loopy scroll state (v, t, x, w) with CPU register side effects and renderer increment/copy strobes.
// State updates land on the edge after the strobe; address mux and attribute select are combinational.
module ppu_scroll (
  input  logic        clk,
  input  logic        rst,
  ppu_scroll_if.slave bus
);
  logic [14:0] v, t, v_nxt, t_nxt;
  logic [2:0]  x, x_nxt;
  logic        w, w_nxt, inc32, inc32_nxt;
  logic [1:0]  quad;
  logic        data_inc, load_v;
  logic [13:0] addr;
  logic [1:0]  attr;

  function automatic logic [14:0] cx_inc(input logic [14:0] a);
    logic [14:0] r;
    r = a;
    if (a[4:0] == 5'd31) begin
      r[4:0] = 5'd0;
      r[10]  = ~a[10];
    end else begin
      r[4:0] = a[4:0] + 5'd1;
    end
    return r;
  endfunction

  function automatic logic [14:0] y_inc(input logic [14:0] a);
    logic [14:0] r;
    r = a;
    if (a[14:12] != 3'd7) begin
      r[14:12] = a[14:12] + 3'd1;
    end else begin
      r[14:12] = 3'd0;
      if (a[9:5] == 5'd29) begin
        r[9:5] = 5'd0;
        r[11]  = ~a[11];
      end else if (a[9:5] == 5'd31) begin
        r[9:5] = 5'd0;
      end else begin
        r[9:5] = a[9:5] + 5'd1;
      end
    end
    return r;
  endfunction

  always_comb begin
    t_nxt     = t;
    x_nxt     = x;
    w_nxt     = w;
    inc32_nxt = inc32;
    data_inc  = 1'b0;
    load_v    = 1'b0;
    if (bus.reg_wr) begin
      case (bus.reg_sel)
        3'd0: begin
          t_nxt[11:10] = bus.reg_din[1:0];
          inc32_nxt    = bus.reg_din[2];
        end
        3'd5: begin
          if (!w) begin
            t_nxt[4:0] = bus.reg_din[7:3];
            x_nxt      = bus.reg_din[2:0];
            w_nxt      = 1'b1;
          end else begin
            t_nxt[14:12] = bus.reg_din[2:0];
            t_nxt[9:5]   = bus.reg_din[7:3];
            w_nxt        = 1'b0;
          end
        end
        3'd6: begin
          if (!w) begin
            t_nxt[13:8] = bus.reg_din[5:0];
            t_nxt[14]   = 1'b0;
            w_nxt       = 1'b1;
          end else begin
            t_nxt[7:0] = bus.reg_din;
            load_v     = 1'b1;
            w_nxt      = 1'b0;
          end
        end
        3'd7:    data_inc = 1'b1;
        default: ;
      endcase
    end else if (bus.reg_rd) begin
      if (bus.reg_sel == 3'd2) w_nxt = 1'b0;
      if (bus.reg_sel == 3'd7) data_inc = 1'b1;
    end
  end

  // Later steps overwrite earlier ones, so the order below encodes priority (lowest first).
  // While rendering, a PPUDATA access glitches into both a coarse-X and a Y increment.
  always_comb begin
    v_nxt = v;
    if (load_v) begin
      v_nxt = t_nxt;
    end else begin
      if (data_inc && !bus.rend)
        v_nxt = v + (inc32 ? 15'd32 : 15'd1);
      if (bus.rend) begin
        if (bus.inc_cx || data_inc) v_nxt = cx_inc(v_nxt);
        if (bus.inc_y || data_inc)  v_nxt = y_inc(v_nxt);
        if (bus.inc_y) begin
          v_nxt[4:0] = t_nxt[4:0];
          v_nxt[10]  = t_nxt[10];
        end
        if (bus.return00) begin
          v_nxt[14:11] = t_nxt[14:11];
          v_nxt[9:5]   = t_nxt[9:5];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v     <= 15'd0;
      t     <= 15'd0;
      x     <= 3'd0;
      w     <= 1'b0;
      inc32 <= 1'b0;
      quad  <= 2'd0;
    end else begin
      v     <= v_nxt;
      t     <= t_nxt;
      x     <= x_nxt;
      w     <= w_nxt;
      inc32 <= inc32_nxt;
      if (bus.fetch_attr) quad <= {v[6], v[1]};
    end
  end

  always_comb begin
    if (bus.fetch_chr)
      addr = {1'b0, bus.pattern_idx};
    else if (bus.fetch_attr)
      addr = {2'b10, v[11:10], 4'b1111, v[9:7], v[4:2]};
    else if (bus.rend)
      addr = {2'b10, v[11:0]};
    else
      addr = v[13:0];
  end

  always_comb begin
    case (quad)
      2'd0:    attr = bus.vram_din[1:0];
      2'd1:    attr = bus.vram_din[3:2];
      2'd2:    attr = bus.vram_din[5:4];
      default: attr = bus.vram_din[7:6];
    endcase
  end

  assign bus.vram_addr = addr;
  assign bus.fine_x    = x;
  assign bus.attr_o    = attr;
endmodule

// File: tb/tb_ppu_scroll.sv
// Directed bench for ppu_scroll with an in-order expectation queue.
module tb_ppu_scroll;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ppu_scroll_if bus();
  ppu_scroll dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    string       tag;
    logic [15:0] exp;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input string tag, input logic [15:0] e);
    exp_t item;
    item.tag = tag;
    item.exp = e;
    sb.push_back(item);
  endtask

  task automatic check(input logic [15:0] obs);
    exp_t e;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL sb_empty: observed %h, nothing expected", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp)
      else begin
        miscompares++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic wr(input logic [2:0] sel, input logic [7:0] din);
    bus.reg_sel = sel;
    bus.reg_din = din;
    bus.reg_wr  = 1'b1;
    tick();
    bus.reg_wr  = 1'b0;
  endtask

  task automatic rd(input logic [2:0] sel);
    bus.reg_sel = sel;
    bus.reg_rd  = 1'b1;
    tick();
    bus.reg_rd  = 1'b0;
  endtask

  function automatic logic [15:0] v_obs();
    return {1'b0, dut.v};
  endfunction

  function automatic logic [15:0] t_obs();
    return {1'b0, dut.t};
  endfunction

  function automatic logic [15:0] w_obs();
    return {15'd0, dut.w};
  endfunction

  function automatic logic [15:0] addr_obs();
    return {2'b00, bus.vram_addr};
  endfunction

  initial begin
    rst             = 1'b1;
    bus.rend        = 1'b0;
    bus.inc_cx      = 1'b0;
    bus.inc_y       = 1'b0;
    bus.return00    = 1'b0;
    bus.fetch_attr  = 1'b0;
    bus.fetch_chr   = 1'b0;
    bus.pattern_idx = 13'd0;
    bus.reg_wr      = 1'b0;
    bus.reg_rd      = 1'b0;
    bus.reg_sel     = 3'd0;
    bus.reg_din     = 8'd0;
    bus.vram_din    = 8'hE7;
    tick();
    tick();
    rst = 1'b0;
    #1;

    // Reset state
    expect_val("rst_addr", 16'h0000);   check(addr_obs());
    expect_val("rst_fine_x", 16'h0000); check({13'd0, bus.fine_x});
    expect_val("rst_attr", 16'h0003);   check({14'd0, bus.attr_o});

    // $2006 pair, then PPUDATA increments by 1 and by 32
    wr(3'd6, 8'h21);
    expect_val("w_after_2006_first", 16'h0001); check(w_obs());
    wr(3'd6, 8'h08);
    #1;
    expect_val("v_load", 16'h2108);    check(v_obs());
    expect_val("w_after_pair", 16'h0000); check(w_obs());
    expect_val("addr_idle", 16'h2108); check(addr_obs());
    rd(3'd7);
    #1;
    expect_val("ppudata_inc1", 16'h2109); check(addr_obs());
    wr(3'd0, 8'h04);
    wr(3'd7, 8'h00);
    #1;
    expect_val("ppudata_inc32", 16'h2129); check(addr_obs());
    wr(3'd0, 8'h00);

    // $2005 pair without and with an intervening $2002 read
    wr(3'd5, 8'h7D);
    wr(3'd5, 8'h5E);
    #1;
    expect_val("scroll_fine_x", 16'h0005); check({13'd0, bus.fine_x});
    expect_val("scroll_t", 16'h616F);      check(t_obs());
    expect_val("scroll_w", 16'h0000);      check(w_obs());
    wr(3'd5, 8'h7D);
    rd(3'd2);
    wr(3'd5, 8'h5E);
    #1;
    expect_val("rd2002_fine_x", 16'h0006); check({13'd0, bus.fine_x});
    expect_val("rd2002_t", 16'h616B);      check(t_obs());
    expect_val("rd2002_w", 16'h0001);      check(w_obs());
    rd(3'd2);

    // Coarse X wrap flips the horizontal nametable
    wr(3'd6, 8'h00);
    wr(3'd6, 8'h1F);
    bus.rend = 1'b1; bus.inc_cx = 1'b1;
    tick();
    bus.inc_cx = 1'b0; bus.rend = 1'b0;
    #1;
    expect_val("cx_wrap", 16'h0400); check(addr_obs());
    wr(3'd6, 8'h00);
    wr(3'd6, 8'h1E);
    bus.rend = 1'b1; bus.inc_cx = 1'b1;
    tick();
    #1;
    expect_val("cx_30_to_31", 16'h201F); check(addr_obs());
    tick();
    bus.inc_cx = 1'b0;
    #1;
    expect_val("cx_31_to_0", 16'h2400); check(addr_obs());
    bus.rend = 1'b0;

    // Y increment from coarse Y 29: wraps and flips v[11]; horizontal copy from t=0x041F
    wr(3'd5, 8'hF8);
    wr(3'd5, 8'hEF);
    wr(3'd0, 8'h00);
    bus.rend = 1'b1; bus.return00 = 1'b1;
    tick();
    bus.return00 = 1'b0; bus.rend = 1'b0;
    wr(3'd0, 8'h01);
    wr(3'd5, 8'hF8);
    wr(3'd5, 8'h00);
    #1;
    expect_val("t_041f", 16'h041F); check(t_obs());
    bus.rend = 1'b1; bus.inc_y = 1'b1;
    tick();
    bus.inc_y = 1'b0; bus.rend = 1'b0;
    #1;
    expect_val("incy_cy29", 16'h0C1F); check(v_obs());

    // Y increment from coarse Y 31: wraps without flipping v[11]
    wr(3'd0, 8'h00);
    wr(3'd5, 8'hF8);
    wr(3'd5, 8'hFF);
    bus.rend = 1'b1; bus.return00 = 1'b1;
    tick();
    bus.return00 = 1'b0; bus.rend = 1'b0;
    wr(3'd0, 8'h01);
    wr(3'd5, 8'hF8);
    wr(3'd5, 8'h00);
    bus.rend = 1'b1; bus.inc_y = 1'b1;
    tick();
    bus.inc_y = 1'b0; bus.rend = 1'b0;
    #1;
    expect_val("incy_cy31", 16'h041F); check(v_obs());

    // Vertical copy held over two cycles: t=0x7BE0 onto v=0x001F
    wr(3'd6, 8'h00);
    wr(3'd6, 8'h1F);
    wr(3'd0, 8'h02);
    wr(3'd5, 8'h00);
    wr(3'd5, 8'hFF);
    bus.rend = 1'b1; bus.return00 = 1'b1;
    tick();
    tick();
    bus.return00 = 1'b0; bus.rend = 1'b0;
    #1;
    expect_val("return00_v", 16'h7BFF);    check(v_obs());
    expect_val("return00_addr", 16'h3BFF); check(addr_obs());

    // Attribute address and quadrant select
    wr(3'd6, 8'h0B);
    wr(3'd6, 8'h5A);
    bus.rend = 1'b1; bus.fetch_attr = 1'b1;
    #1;
    expect_val("attr_addr", 16'h2BF6); check(addr_obs());
    tick();
    bus.fetch_attr = 1'b0; bus.vram_din = 8'hE4;
    #1;
    expect_val("attr_quad3", 16'h0003); check({14'd0, bus.attr_o});
    bus.fetch_chr = 1'b1; bus.fetch_attr = 1'b1; bus.pattern_idx = 13'h1ABC;
    #1;
    expect_val("chr_addr", 16'h1ABC); check(addr_obs());
    bus.fetch_chr = 1'b0; bus.fetch_attr = 1'b0; bus.rend = 1'b0;
    wr(3'd6, 8'h00);
    wr(3'd6, 8'h00);
    bus.rend = 1'b1; bus.fetch_attr = 1'b1;
    tick();
    bus.fetch_attr = 1'b0; bus.rend = 1'b0;
    #1;
    expect_val("attr_quad0", 16'h0000); check({14'd0, bus.attr_o});

    // $2006 second write outranks return00 and inc_cx on the same edge
    wr(3'd6, 8'h3F);
    bus.rend = 1'b1; bus.return00 = 1'b1; bus.inc_cx = 1'b1;
    wr(3'd6, 8'h80);
    bus.rend = 1'b0; bus.return00 = 1'b0; bus.inc_cx = 1'b0;
    #1;
    expect_val("load_priority", 16'h3F80); check(v_obs());

    // Reset mid-frame with a concurrent strobe
    wr(3'd6, 8'h12);
    wr(3'd6, 8'h34);
    wr(3'd5, 8'h05);
    rst = 1'b1; bus.rend = 1'b1; bus.inc_cx = 1'b1;
    tick();
    rst = 1'b0; bus.rend = 1'b0; bus.inc_cx = 1'b0;
    #1;
    expect_val("midrst_v", 16'h0000);      check(v_obs());
    expect_val("midrst_t", 16'h0000);      check(t_obs());
    expect_val("midrst_fine_x", 16'h0000); check({13'd0, bus.fine_x});
    expect_val("midrst_w", 16'h0000);      check(w_obs());
    expect_val("midrst_addr", 16'h0000);   check(addr_obs());

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
